add16_share_ctrl: RTL and testbench

Time-shared controller for one 16-bit approximate adder. It arbitrates NREQ requesters round-robin and sends approximate requests through the external approximate adder. Requests flagged exact are computed on a small internal two-pass 8-bit exact adder. Sits between the accelerator lanes and the single approximate adder instance, so the adder's power and area are paid once per cluster.

---
 rtl/add16_share_pkg.sv | 23 ++
 rtl/add16_share_ctrl_if.sv | 41 ++++
 rtl/add16_share_ctrl_rr_arbiter.sv | 30 +++
 rtl/add16_share_ctrl.sv | 120 ++++++++++++
 tb/tb_add16_share_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/add16_share_pkg.sv
// Shared types and sizing helpers for the approximate-adder share controller.
// Imported by the interface, the arbiter and the controller top.
package add16_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 16;
    localparam int HALF     = DEF_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXHI = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/add16_share_ctrl_if.sv
// Requester, consumer and external approximate-adder bundle.
// master = cluster side, slave = share controller.
interface add16_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    import add16_share_pkg::*;

    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_exact;

    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W:0]        resp_sum;
    logic              resp_exact;

    logic [W-1:0]      ax_a;
    logic [W-1:0]      ax_b;
    logic [W:0]        ax_o;

    modport master (
        output req_valid, req_a, req_b, req_exact,
        output resp_ready, ax_o,
        input  req_ready, resp_valid, resp_id,
        input  resp_sum, resp_exact, ax_a, ax_b
    );

    modport slave (
        input  req_valid, req_a, req_b, req_exact,
        input  resp_ready, ax_o,
        output req_ready, resp_valid, resp_id,
        output resp_sum, resp_exact, ax_a, ax_b
    );

endinterface

// File: rtl/add16_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// Combinational; grant is one-hot and zero when disabled.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (en && !any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/add16_share_ctrl.sv
// Time-shares one external approximate adder among NREQ requesters;
// exact requests take two passes through an internal half-width adder.
module add16_share_ctrl
    import add16_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W
) (
    input  logic               clk,
    input  logic               rst,
    add16_share_ctrl_if.slave  bus
);

    localparam int IDW = id_w(NREQ);
    localparam int HW  = half_w(W);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] EXHI = ST_EXHI;
    localparam logic [1:0] OUT  = ST_OUT;

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] gnt;
    logic            any;
    logic            accept;
    logic            gexact;
    logic            approx_go;
    logic [W-1:0]    ga;
    logic [W-1:0]    gb;
    logic [HW:0]     lo;
    logic [HW:0]     hi;

    logic [HW-1:0]   ex_lo;
    logic [HW-1:0]   ex_ahi;
    logic [HW-1:0]   ex_bhi;
    logic            ex_c;

    logic [W:0]      sum_q;
    logic [IDW-1:0]  id_q;
    logic            exact_q;

    // No grant may be offered while reset is held.
    assign accept = ~rst & ((state == IDLE) |
                            ((state == OUT) & bus.resp_ready));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req  (bus.req_valid),
        .ptr  (ptr),
        .en   (accept),
        .gnt  (gnt),
        .idx  (gidx),
        .any  (any)
    );

    assign ga        = bus.req_a[gidx*W +: W];
    assign gb        = bus.req_b[gidx*W +: W];
    assign gexact    = bus.req_exact[gidx];
    assign approx_go = any & ~gexact;

    assign bus.req_ready = gnt;

    // Operand isolation keeps the shared adder quiet when unused.
    assign bus.ax_a = approx_go ? ga : '0;
    assign bus.ax_b = approx_go ? gb : '0;

    assign lo = {1'b0, ga[HW-1:0]} + {1'b0, gb[HW-1:0]};
    assign hi = {1'b0, ex_ahi} + {1'b0, ex_bhi} + {{HW{1'b0}}, ex_c};

    assign bus.resp_valid = (state == OUT);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_exact = exact_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IDW'(NREQ - 1);
            id_q    <= '0;
            sum_q   <= '0;
            exact_q <= 1'b0;
            ex_lo   <= '0;
            ex_ahi  <= '0;
            ex_bhi  <= '0;
            ex_c    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, OUT: begin
                    if (any) begin
                        ptr  <= gidx;
                        id_q <= gidx;
                        if (gexact) begin
                            ex_lo  <= lo[HW-1:0];
                            ex_c   <= lo[HW];
                            ex_ahi <= ga[W-1:HW];
                            ex_bhi <= gb[W-1:HW];
                            state  <= EXHI;
                        end else begin
                            sum_q   <= bus.ax_o;
                            exact_q <= 1'b0;
                            state   <= OUT;
                        end
                    end else if (accept) begin
                        state <= IDLE;
                    end
                end
                EXHI: begin
                    sum_q   <= {hi, ex_lo};
                    exact_q <= 1'b1;
                    state   <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_share_ctrl.sv
// Scoreboard bench for add16_share_ctrl with a latency-level model
// of arbitration and a behavioural approximate adder on ax_o.
module tb_add16_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 16;

    typedef struct {
        int         id;
        logic [W:0] sum;
        logic       ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add16_share_ctrl_if #(.NREQ(NREQ), .W(W)) bus();

    add16_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] rx;
    logic [W-1:0]    ra [NREQ];
    logic [W-1:0]    rb [NREQ];
    logic            stub;
    logic [NREQ-1:0] gr;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // Lower-part-OR approximate adder: low 4 bits ORed, upper bits added.
    function automatic logic [W:0] approx_f(logic [W-1:0] a, logic [W-1:0] b);
        logic [12:0] h;
        h = {1'b0, a[15:4]} + {1'b0, b[15:4]};
        return {h, a[3:0] | b[3:0]};
    endfunction

    always_comb begin
        bus.req_valid = rv;
        bus.req_exact = rx;
        bus.req_a     = '0;
        bus.req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = ra[i];
            bus.req_b[i*W +: W] = rb[i];
        end
    end

    always_comb bus.ax_o = stub ? 17'h1ABCD : approx_f(bus.ax_a, bus.ax_b);

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Request-level model: who should win, when results appear.
    always @(negedge clk) begin : model_p
        static int mptr = NREQ - 1;
        static bit busy = 0;
        static int due  = 0;
        static int cyc  = 0;
        bit              ev;
        bit              win;
        int              g;
        logic [NREQ-1:0] eg;
        logic [W-1:0]    ea;
        logic [W-1:0]    eb;
        exp_t            e;
        cyc++;
        if (rst) begin
            busy = 0;
            mptr = NREQ - 1;
            sb.delete();
        end else begin
            ev = busy && (cyc >= due);
            chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
            win = !busy || (ev && bus.resp_ready);
            g = -1;
            if (win)
                for (int k = 1; k <= NREQ; k++)
                    if (g < 0 && rv[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            eg = '0;
            ea = '0;
            eb = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                if (!rx[g]) begin
                    ea = ra[g];
                    eb = rb[g];
                end
            end
            chk("req_ready", 64'(bus.req_ready), 64'(eg));
            chk("ax_operands", {32'd0, bus.ax_a, bus.ax_b}, {32'd0, ea, eb});
            if (ev && bus.resp_ready) busy = 0;
            if (g >= 0) begin
                e.id  = g;
                e.ex  = rx[g];
                if (rx[g])     e.sum = 17'(ra[g]) + 17'(rb[g]);
                else if (stub) e.sum = 17'h1ABCD;
                else           e.sum = approx_f(ra[g], rb[g]);
                sb.push_back(e);
                busy = 1;
                due  = cyc + (rx[g] ? 2 : 1);
                mptr = g;
            end
        end
    end

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin : mon_p
        exp_t e;
        if (!rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d sum %0h, required no response",
                         bus.resp_id, bus.resp_sum);
            end else begin
                e = sb[0];
                chk("resp_id", 64'(bus.resp_id), 64'(e.id));
                chk("resp_sum", 64'(bus.resp_sum), 64'(e.sum));
                chk("resp_exact", 64'(bus.resp_exact), 64'(e.ex));
                if (bus.resp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic new_op(int i, bit x);
        rv[i] = 1'b1;
        rx[i] = x;
        ra[i] = 16'($urandom);
        rb[i] = 16'($urandom);
    endtask

    task automatic set_op(int i, bit x, logic [W-1:0] a, logic [W-1:0] b);
        rv[i] = 1'b1;
        rx[i] = x;
        ra[i] = a;
        rb[i] = b;
    endtask

    // One cycle: sample grants mid-cycle, then update requesters after the edge.
    task automatic step(int mode);
        @(negedge clk);
        gr = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (gr[i]) begin
                case (mode)
                    1:       new_op(i, 1'b0);
                    2:       new_op(i, 1'($urandom % 2));
                    3:       if ($urandom % 10 < 7) new_op(i, 1'($urandom % 2));
                             else rv[i] = 1'b0;
                    default: rv[i] = 1'b0;
                endcase
            end else if (mode == 3) begin
                if (!rv[i] && $urandom % 10 < 4) new_op(i, 1'($urandom % 2));
                else if (rv[i] && $urandom % 20 == 0) rv[i] = 1'b0;
            end
        end
        if (mode == 3) bus.resp_ready = ($urandom % 4 != 0);
    endtask

    task automatic drain();
        rv = '0;
        bus.resp_ready = 1'b1;
        repeat (4) step(0);
    endtask

    initial begin : drv_p
        bit got;
        rv = '0;
        rx = '0;
        gr = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        stub = 1'b1;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        set_op(0, 1'b0, 16'h1357, 16'h2468);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_sum", 64'(bus.resp_sum), 64'd0);
        chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
        chk("rst_resp_exact", 64'(bus.resp_exact), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_ax_a", 64'(bus.ax_a), 64'd0);

        // Stubbed approximate adder, requester 0 first after reset.
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (4) step(0);

        // Exact path with full carry ripple and carry into the high half.
        stub = 1'b0;
        set_op(2, 1'b1, 16'hFFFF, 16'h0001);
        repeat (4) step(0);
        set_op(2, 1'b1, 16'h00FF, 16'h0001);
        repeat (4) step(0);

        // All requesters continuously valid: one approximate grant per cycle.
        for (int i = 0; i < NREQ; i++) new_op(i, 1'b0);
        repeat (12) step(1);
        drain();

        // Consumer stall for five cycles in OUT.
        for (int i = 0; i < NREQ; i++) new_op(i, 1'b0);
        repeat (2) step(1);
        bus.resp_ready = 1'b0;
        repeat (5) step(1);
        bus.resp_ready = 1'b1;
        repeat (3) step(1);
        drain();

        // Reset while an exact operation is in its second pass.
        new_op(1, 1'b1);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(0);
            got = gr[1];
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL exact_grant_timeout: got no grant, required grant of requester 1");
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("async_rst_resp_sum", 64'(bus.resp_sum), 64'd0);
        chk("async_rst_resp_exact", 64'(bus.resp_exact), 64'd0);
        new_op(3, 1'b0);
        new_op(0, 1'b0);
        #1;
        chk("async_rst_req_ready", 64'(bus.req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) step(0);
        drain();

        // Requesters 1 and 3 alternating with mixed exact/approximate.
        new_op(1, 1'($urandom % 2));
        new_op(3, 1'($urandom % 2));
        repeat (30) step(2);
        drain();

        // Random traffic, random drops and consumer back-pressure.
        repeat (3000) step(3);
        drain();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
